nono_line_engine: RTL and testbench
===================================

# nono_line_engine

Parametrised nonogram line-elimination core, MAX_SIZE×MAX_SIZE board. Consumes a stream of per-line beats from the option FIFO: one header beat carrying the line index, then that line's surviving options. Per option it flags put-back or drop. At line end it commits the cells common to all consistent options into `known`/`assigned`. It tracks per-line option counts internally and reports `solved` and `contradiction`.

## Interface
- MAX_SIZE, 11, maximum rows/cols; option width.
- CNT_W, 7, per-line option-count width.
- IDX_W, $clog2(2*MAX_SIZE), line-index width.
- DIM_W, $clog2(MAX_SIZE+1), width of num_rows/num_cols.

- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- started  in  1  single-cycle pulse that begins a new puzzle; legal in any state.
- num_rows  in  DIM_W  active rows; sampled on started.
- num_cols  in  DIM_W  active cols; sampled on started.
- old_options_amnt  in  2*MAX_SIZE*CNT_W  initial counts:
  - rows occupy lines 0..num_rows-1;
  - columns occupy num_rows..num_rows+num_cols-1;
  - sampled on started.
- valid_in  in  1  beat valid.
- option  in  MAX_SIZE  beat data; header beats use option[IDX_W-1:0]; bit i = cell i (leftmost col / topmost row).
- ready  out  1  beat accepted on a rising edge when valid_in&&ready.
- new_line  out  1  next accepted beat is a header.
- result_valid  out  1  one-cycle strobe; put_back_to_FIFO is meaningful.
- put_back_to_FIFO  out  1  1 = re-queue option, 0 = drop.
- known  out  MAX_SIZE*MAX_SIZE  row-major, bit r*MAX_SIZE+c.
- assigned  out  MAX_SIZE*MAX_SIZE  cell value; meaningful only where known.
- solved  out  1  all active cells known; sticky.
- contradiction  out  1  a live line had zero consistent options; sticky.

## Operation
- States: IDLE, LOAD, HEADER, OPTION, COMMIT, DONE.
- IDLE: ready=0; started → LOAD.
- LOAD (1 cycle, ready=0):
  - clear known/assigned/solved/contradiction;
  - latch dims and counts;
  - → HEADER.
- HEADER (ready=1, new_line=1): accept index L.
  - L ≥ num_rows+num_cols: ignored, stay.
  - Otherwise:
    - latch L and line mask (num_cols bits for rows, num_rows bits for columns);
    - extract line_known/line_assigned;
    - and_acc=all ones, or_acc=0, cons=0, beats=count[L];
    - if count[L]==0 (retired line), stay in HEADER; else → OPTION.
- OPTION (ready=1): consistent iff ((option^line_assigned)&line_known&mask)==0.
  - Consistent: and_acc&=option, or_acc|=option, cons++.
  - put_back_to_FIFO = consistent && count[L]≥2. A sole option (count 1) is consumed and never re-queued.
  - After beats options accepted → COMMIT.
- COMMIT (1 cycle, ready=0, new_line=0):
  - cons==0: contradiction=1, → DONE.
  - Otherwise:
    - new_known = mask&(and_acc|~or_acc), OR-ed into known for line L; assigned for those cells = and_acc bit;
    - count[L] = (count[L]==1) ? 0 : cons;
    - if all active cells known after the update: solved=1, → DONE; else → HEADER.
- DONE: ready=0, new_line=0; holds until started or rst.
- started in any state → LOAD, aborting the current line. No result_valid for an aborted beat.
- Out-of-area bits (beyond dims) of known/assigned stay 0. solved ignores them.
- Counts saturate at CNT_W width. cons never exceeds the stored count.

## Timing
- Reset (async): state IDLE; every output 0; counts 0.
- result_valid/put_back_to_FIFO: registered, high exactly the cycle after each accepted option beat.
- A line of k options occupies:
  - 1 header cycle;
  - k option cycles;
  - 1 COMMIT cycle.
- known/assigned update visible the cycle after COMMIT.
- solved/contradiction rise in that same cycle.
- Back-pressure: valid_in low holds the state; the accumulators hold.
- Header immediately after COMMIT: ready reasserts the cycle after COMMIT. Minimum gap is 1 bubble per line.
- started and valid_in in the same cycle: started wins; the beat is not accepted.

## Test plan
- Reset mid-OPTION:
  - all outputs 0, ready=0;
  - after started+LOAD: new_line=1, ready=1.
- 3×3, counts {2,3,1,1,2,3}; header 0, options 110, 011:
  - put_back 1,1;
  - after COMMIT: known[0][1]=1, assigned[0][1]=1, count[0]=2.
- Header 2, option 101 (count 1):
  - put_back 0;
  - row 2 known=111, assigned=101, count[2]=0;
  - a later header 2 returns straight to HEADER.
- Full round 1 plus the round 2 sequence for board 110/010/101:
  - solved=1 after column-2 commit; known active=all 1;
  - assigned rows 110,010,101; state DONE, ready=0.
- Contradiction:
  - after row 2 = 101 is committed, feed column 0 (count 2) with 010, 000;
  - both put_back 0, contradiction=1, DONE.
- Back-pressure: valid_in gaps inside an option run:
  - results identical to the gap-free run;
  - started asserted together with valid_in ⇒ beat dropped; known cleared.

Source files
------------

// File: rtl/nono_line_engine.sv
// Nonogram line-elimination core: filters one line's surviving options against the board
// and commits the cells that every consistent option agrees on.
// state   | meaning
// IDLE    | waiting for started
// LOAD    | clear board, start HEADER
// HEADER  | expecting a line-index beat
// OPTION  | filtering the line's options
// COMMIT  | folding accumulators into known/assigned
// DONE    | solved or contradiction, holds until started
module nono_line_engine #(
    parameter int MAX_SIZE = 11,
    parameter int CNT_W    = 7,
    parameter int IDX_W    = $clog2(2*MAX_SIZE),
    parameter int DIM_W    = $clog2(MAX_SIZE+1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          started,
    input  logic [DIM_W-1:0]              num_rows,
    input  logic [DIM_W-1:0]              num_cols,
    input  logic [2*MAX_SIZE*CNT_W-1:0]   old_options_amnt,
    input  logic                          valid_in,
    input  logic [MAX_SIZE-1:0]           option,
    output logic                          ready,
    output logic                          new_line,
    output logic                          result_valid,
    output logic                          put_back_to_FIFO,
    output logic [MAX_SIZE*MAX_SIZE-1:0]  known,
    output logic [MAX_SIZE*MAX_SIZE-1:0]  assigned,
    output logic                          solved,
    output logic                          contradiction
);
    localparam int NL = 2*MAX_SIZE;
    localparam int AW = MAX_SIZE*MAX_SIZE;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_HEADER = 3'd2;
    localparam logic [2:0] S_OPTION = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]          state;
    logic [DIM_W-1:0]    rows_q, cols_q;
    logic [CNT_W-1:0]    cnt [NL];
    logic [IDX_W-1:0]    line_q, line_sub;
    logic                line_is_col;
    logic [MAX_SIZE-1:0] mask_q, lk_q, la_q, and_acc, or_acc;
    logic [CNT_W-1:0]    cons, beats;

    logic [IDX_W-1:0]    hdr_idx;
    logic                hdr_ok, h_is_col;
    int                  h_sub;
    logic [MAX_SIZE-1:0] h_mask, h_known, h_assigned;
    logic [CNT_W-1:0]    cnt_cur;
    logic                cons_ok;
    logic [MAX_SIZE-1:0] new_known;
    logic [AW-1:0]       known_nxt, assigned_nxt, active;
    logic                all_known;

    assign ready    = ((state == S_HEADER) || (state == S_OPTION)) && !started;
    assign new_line = (state == S_HEADER);
    assign hdr_idx  = option[IDX_W-1:0];
    assign hdr_ok   = int'(hdr_idx) < (int'(rows_q) + int'(cols_q));
    assign h_is_col = int'(hdr_idx) >= int'(rows_q);
    assign h_sub    = h_is_col ? (int'(hdr_idx) - int'(rows_q)) : int'(hdr_idx);
    assign cnt_cur  = cnt[line_q];
    assign cons_ok  = ((option ^ la_q) & lk_q & mask_q) == '0;
    assign new_known = mask_q & (and_acc | ~or_acc);

    always_comb begin
        int pos;
        h_mask     = '0;
        h_known    = '0;
        h_assigned = '0;
        for (int i = 0; i < MAX_SIZE; i++) begin
            pos = h_is_col ? (i*MAX_SIZE + h_sub) : (h_sub*MAX_SIZE + i);
            if (hdr_ok && pos < AW &&
                (h_is_col ? (i < int'(rows_q)) : (i < int'(cols_q)))) begin
                h_mask[i]     = 1'b1;
                h_known[i]    = known[pos];
                h_assigned[i] = assigned[pos];
            end
        end
    end

    always_comb begin
        int pos;
        known_nxt    = known;
        assigned_nxt = assigned;
        active       = '0;
        for (int i = 0; i < MAX_SIZE; i++) begin
            pos = line_is_col ? (i*MAX_SIZE + int'(line_sub)) : (int'(line_sub)*MAX_SIZE + i);
            if (new_known[i] && pos < AW) begin
                known_nxt[pos]    = 1'b1;
                assigned_nxt[pos] = and_acc[i];
            end
        end
        for (int r = 0; r < MAX_SIZE; r++)
            for (int c = 0; c < MAX_SIZE; c++)
                active[r*MAX_SIZE+c] = (r < int'(rows_q)) && (c < int'(cols_q));
        all_known = (known_nxt & active) == active;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            rows_q           <= '0;
            cols_q           <= '0;
            for (int l = 0; l < NL; l++) cnt[l] <= '0;
            line_q           <= '0;
            line_sub         <= '0;
            line_is_col      <= 1'b0;
            mask_q           <= '0;
            lk_q             <= '0;
            la_q             <= '0;
            and_acc          <= '0;
            or_acc           <= '0;
            cons             <= '0;
            beats            <= '0;
            result_valid     <= 1'b0;
            put_back_to_FIFO <= 1'b0;
            known            <= '0;
            assigned         <= '0;
            solved           <= 1'b0;
            contradiction    <= 1'b0;
        end else begin
            result_valid     <= 1'b0;
            put_back_to_FIFO <= 1'b0;
            if (started) begin
                // Abort whatever is in flight; the pending beat is not accepted.
                state  <= S_LOAD;
                rows_q <= num_rows;
                cols_q <= num_cols;
                for (int l = 0; l < NL; l++)
                    cnt[l] <= old_options_amnt[l*CNT_W +: CNT_W];
            end else begin
                case (state)
                    S_LOAD: begin
                        known         <= '0;
                        assigned      <= '0;
                        solved        <= 1'b0;
                        contradiction <= 1'b0;
                        state         <= S_HEADER;
                    end
                    S_HEADER: begin
                        if (valid_in && hdr_ok) begin
                            line_q      <= hdr_idx;
                            line_sub    <= IDX_W'(h_sub);
                            line_is_col <= h_is_col;
                            mask_q      <= h_mask;
                            lk_q        <= h_known;
                            la_q        <= h_assigned;
                            and_acc     <= '1;
                            or_acc      <= '0;
                            cons        <= '0;
                            beats       <= cnt[hdr_idx];
                            state       <= (cnt[hdr_idx] == '0) ? S_HEADER : S_OPTION;
                        end
                    end
                    S_OPTION: begin
                        if (valid_in) begin
                            result_valid     <= 1'b1;
                            put_back_to_FIFO <= cons_ok && (cnt_cur > CNT_W'(1));
                            if (cons_ok) begin
                                and_acc <= and_acc & option;
                                or_acc  <= or_acc | option;
                                cons    <= cons + CNT_W'(1);
                            end
                            beats <= beats - CNT_W'(1);
                            if (beats == CNT_W'(1)) state <= S_COMMIT;
                        end
                    end
                    S_COMMIT: begin
                        if (cons == '0) begin
                            contradiction <= 1'b1;
                            state         <= S_DONE;
                        end else begin
                            known        <= known_nxt;
                            assigned     <= assigned_nxt;
                            cnt[line_q]  <= (cnt_cur == CNT_W'(1)) ? '0 : cons;
                            if (all_known) begin
                                solved <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                state  <= S_HEADER;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nono_line_engine.sv
// Directed bench for nono_line_engine on a 3x3 board (solution rows 110/010/101, cell 0 = bit 0).
module tb_nono_line_engine;
    localparam int MS = 11;
    localparam int CW = 7;
    localparam int AW = MS*MS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              started = 1'b0;
    logic [3:0]        num_rows = 4'd3;
    logic [3:0]        num_cols = 4'd3;
    logic [2*MS*CW-1:0] amnt = '0;
    logic              valid_in = 1'b0;
    logic [MS-1:0]     option = '0;
    logic              ready, new_line, result_valid, put_back;
    logic [AW-1:0]     known, assigned;
    logic              solved, contradiction;

    int checks = 0;
    int errors = 0;

    nono_line_engine dut (
        .clk(clk), .rst(rst), .started(started),
        .num_rows(num_rows), .num_cols(num_cols),
        .old_options_amnt(amnt), .valid_in(valid_in), .option(option),
        .ready(ready), .new_line(new_line), .result_valid(result_valid),
        .put_back_to_FIFO(put_back), .known(known), .assigned(assigned),
        .solved(solved), .contradiction(contradiction)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [AW-1:0] brd(input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2);
        logic [AW-1:0] v;
        v = '0;
        v[0 +: 3]    = r0;
        v[MS +: 3]   = r1;
        v[2*MS +: 3] = r2;
        return v;
    endfunction

    function automatic logic [2*MS*CW-1:0] mkcnt(input logic [6:0] c0, input logic [6:0] c1,
                                                  input logic [6:0] c2, input logic [6:0] c3,
                                                  input logic [6:0] c4, input logic [6:0] c5);
        logic [2*MS*CW-1:0] v;
        v = '0;
        v[0*CW +: CW] = c0; v[1*CW +: CW] = c1; v[2*CW +: CW] = c2;
        v[3*CW +: CW] = c3; v[4*CW +: CW] = c4; v[5*CW +: CW] = c5;
        return v;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        if (!ready) chk1({tag, "_ready_timeout"}, ready, 1'b1);
    endtask

    task automatic do_start(input logic [2*MS*CW-1:0] c);
        amnt    = c;
        started = 1'b1;
        tick();
        started = 1'b0;
        tick();
    endtask

    task automatic hdr(input int idx);
        wait_ready("hdr");
        valid_in = 1'b1;
        option   = MS'(idx);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic opt(input string tag, input logic [MS-1:0] data, input logic exp_pb);
        wait_ready(tag);
        valid_in = 1'b1;
        option   = data;
        tick();
        valid_in = 1'b0;
        chk1({tag, "_rv"}, result_valid, 1'b1);
        chk1({tag, "_pb"}, put_back, exp_pb);
    endtask

    initial begin
        tick();
        rst = 1'b0;
        chk1("rst_ready", ready, 1'b0);
        chkv("rst_known", known, '0);

        // Reset mid-OPTION
        do_start(mkcnt(2, 3, 1, 1, 2, 3));
        hdr(0);
        opt("pre_o0", 11'b011, 1'b1);
        rst = 1'b1;
        #1;
        chk1("arst_ready", ready, 1'b0);
        chk1("arst_newline", new_line, 1'b0);
        chk1("arst_rv", result_valid, 1'b0);
        chk1("arst_pb", put_back, 1'b0);
        tick();
        rst = 1'b0;
        do_start(mkcnt(2, 3, 1, 1, 2, 3));
        chk1("load_newline", new_line, 1'b1);
        chk1("load_ready", ready, 1'b1);

        // Round 1 of the 3x3 puzzle
        hdr(0);
        opt("r0_o0", 11'b011, 1'b1);
        opt("r0_o1", 11'b110, 1'b1);
        tick();
        chkv("r0_known", known, brd(3'b010, 3'b000, 3'b000));
        chkv("r0_assigned", assigned, brd(3'b010, 3'b000, 3'b000));

        hdr(1);
        opt("r1_o0", 11'b001, 1'b1);
        opt("r1_o1", 11'b010, 1'b1);
        opt("r1_o2", 11'b100, 1'b1);
        tick();
        chkv("r1_known", known, brd(3'b010, 3'b000, 3'b000));

        hdr(2);
        opt("r2_o0", 11'b101, 1'b0);
        tick();
        chkv("r2_known", known, brd(3'b010, 3'b000, 3'b111));
        chkv("r2_assigned", assigned, brd(3'b010, 3'b000, 3'b101));
        hdr(2);
        chk1("retired_newline", new_line, 1'b1);
        chk1("retired_ready", ready, 1'b1);

        hdr(3);
        opt("c0_o0", 11'b101, 1'b0);
        tick();
        chkv("c0_known", known, brd(3'b011, 3'b001, 3'b111));
        chkv("c0_assigned", assigned, brd(3'b011, 3'b000, 3'b101));

        hdr(4);
        opt("c1_o0", 11'b011, 1'b1);
        opt("c1_o1", 11'b110, 1'b0);
        tick();
        chkv("c1_known", known, brd(3'b011, 3'b011, 3'b111));
        chk1("c1_solved", solved, 1'b0);

        hdr(5);
        opt("c2_o0", 11'b001, 1'b0);
        opt("c2_o1", 11'b010, 1'b0);
        opt("c2_o2", 11'b100, 1'b1);
        tick();
        chkv("c2_known", known, brd(3'b111, 3'b111, 3'b111));
        chkv("c2_assigned", assigned, brd(3'b011, 3'b010, 3'b101));
        chk1("c2_solved", solved, 1'b1);
        chk1("done_ready", ready, 1'b0);
        chk1("done_newline", new_line, 1'b0);
        chk1("done_contra", contradiction, 1'b0);

        // Back-pressure inside an option run
        do_start(mkcnt(2, 3, 1, 1, 2, 3));
        chkv("restart_known", known, '0);
        chk1("restart_solved", solved, 1'b0);
        hdr(0);
        opt("bp_o0", 11'b011, 1'b1);
        tick();
        chk1("bp_gap_rv", result_valid, 1'b0);
        tick();
        chk1("bp_gap_ready", ready, 1'b1);
        chk1("bp_gap_newline", new_line, 1'b0);
        opt("bp_o1", 11'b110, 1'b1);
        tick();
        chkv("bp_known", known, brd(3'b010, 3'b000, 3'b000));
        chkv("bp_assigned", assigned, brd(3'b010, 3'b000, 3'b000));

        // started together with valid_in aborts the line and drops the beat
        hdr(1);
        opt("ab_o0", 11'b001, 1'b1);
        amnt     = mkcnt(2, 3, 1, 2, 2, 3);
        valid_in = 1'b1;
        option   = 11'b010;
        started  = 1'b1;
        tick();
        started  = 1'b0;
        valid_in = 1'b0;
        chk1("abort_rv", result_valid, 1'b0);
        tick();
        chkv("abort_known", known, '0);
        chk1("abort_newline", new_line, 1'b1);

        // Contradiction on column 0 after row 2 is fixed
        hdr(2);
        opt("ct_r2", 11'b101, 1'b0);
        tick();
        chkv("ct_r2_known", known, brd(3'b000, 3'b000, 3'b111));
        hdr(7);
        chk1("bad_idx_newline", new_line, 1'b1);
        hdr(3);
        opt("ct_o0", 11'b010, 1'b0);
        opt("ct_o1", 11'b000, 1'b0);
        tick();
        chk1("ct_contra", contradiction, 1'b1);
        chk1("ct_ready", ready, 1'b0);
        chk1("ct_solved", solved, 1'b0);
        chkv("ct_known", known, brd(3'b000, 3'b000, 3'b111));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
